ftm_recovery_ctrl: RTL and testbench

Recovery sequencer for the fault tolerance module of the dual-core lockstep system. When the register-write comparator flags a mismatch, this block halts both cores, pulses the core reset, and restores every architectural register from the checkpoint store. It then reloads the saved PC and waits for the cores to resume. It also counts consecutive retries and latches a fatal flag when the fault persists.

---
 rtl/ftm_recovery_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ftm_recovery_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ftm_recovery_ctrl.sv
// Recovery sequencer for the dual-core lockstep fault tolerance module: halts and resets the
// cores, restores the register file from the checkpoint store, reloads the PC, escalates to fatal.
module ftm_recovery_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  error_i,
  input  logic                  checkpoint_i,
  input  logic                  done_i,
  input  logic [31:0]           spc_i,
  output logic                  ckpt_re_o,
  output logic [ADDR_WIDTH-1:0] ckpt_raddr_o,
  input  logic [DATA_WIDTH-1:0] ckpt_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  pc_we_o,
  output logic [31:0]           pc_o,
  output logic                  halt_o,
  output logic                  reset_o,
  output logic                  recover_o,
  output logic                  fatal_o
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned CycW   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned IdxW   = ADDR_WIDTH + 1;

  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [CycW-1:0]   CycLast  = CycW'(RESET_CYCLES - 1);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(NUM_REGS);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StReset,
    StRestore,
    StPc,
    StWaitDone,
    StFatal
  } state_e;

  state_e            state_q, state_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      retry_q <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cyc_d   = '0;
    idx_d   = '0;
    unique case (state_q)
      StIdle: begin
        // An error in the same cycle as a checkpoint wins and keeps the retry count.
        if (enable_i && error_i) begin
          if (retry_q == RetryMax) begin
            state_d = StFatal;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StHalt;
          end
        end else if (checkpoint_i) begin
          retry_d = '0;
        end
      end
      StHalt: state_d = StReset;
      StReset: begin
        if (cyc_q == CycLast) begin
          state_d = StRestore;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StRestore: begin
        // idx runs 0..NUM_REGS; the extra step lets the last read's data be written.
        if (idx_q == IdxLast) begin
          state_d = StPc;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StPc: state_d = StWaitDone;
      StWaitDone: begin
        if (done_i) state_d = StIdle;
      end
      StFatal: state_d = StFatal;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ckpt_re_o    = 1'b0;
    ckpt_raddr_o = '0;
    rf_we_o      = 1'b0;
    rf_addr_o    = '0;
    pc_we_o      = 1'b0;
    pc_o         = '0;
    halt_o       = 1'b0;
    reset_o      = 1'b0;
    recover_o    = 1'b0;
    fatal_o      = 1'b0;
    unique case (state_q)
      StHalt: begin
        halt_o    = 1'b1;
        recover_o = 1'b1;
      end
      StReset: begin
        halt_o    = 1'b1;
        reset_o   = 1'b1;
        recover_o = 1'b1;
      end
      StRestore: begin
        halt_o    = 1'b1;
        recover_o = 1'b1;
        if (idx_q < IdxLast) begin
          ckpt_re_o    = 1'b1;
          ckpt_raddr_o = idx_q[ADDR_WIDTH-1:0];
        end
        if (idx_q != '0) begin
          rf_we_o   = 1'b1;
          rf_addr_o = idx_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
        end
      end
      StPc: begin
        halt_o    = 1'b1;
        recover_o = 1'b1;
        pc_we_o   = 1'b1;
        pc_o      = spc_i;
      end
      StWaitDone: recover_o = 1'b1;
      StFatal: begin
        halt_o  = 1'b1;
        fatal_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_wdata_o = ckpt_rdata_i;

endmodule

// File: tb/tb_ftm_recovery_ctrl.sv
// Directed bench for ftm_recovery_ctrl with default parameters and a behavioural checkpoint store
// that returns 0x100+addr one cycle after each read.
module tb_ftm_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        error = 1'b1;
  logic        checkpoint = 1'b0;
  logic        done = 1'b0;
  logic [31:0] spc = 32'h0000_0080;
  logic        ckpt_re;
  logic [5:0]  ckpt_raddr;
  logic [31:0] ckpt_rdata = '0;
  logic        rf_we;
  logic [5:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        pc_we;
  logic [31:0] pc;
  logic        halt;
  logic        core_reset;
  logic        recover;
  logic        fatal;

  int tests = 0;
  int failed = 0;

  ftm_recovery_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .error_i     (error),
    .checkpoint_i(checkpoint),
    .done_i      (done),
    .spc_i       (spc),
    .ckpt_re_o   (ckpt_re),
    .ckpt_raddr_o(ckpt_raddr),
    .ckpt_rdata_i(ckpt_rdata),
    .rf_we_o     (rf_we),
    .rf_addr_o   (rf_addr),
    .rf_wdata_o  (rf_wdata),
    .pc_we_o     (pc_we),
    .pc_o        (pc),
    .halt_o      (halt),
    .reset_o     (core_reset),
    .recover_o   (recover),
    .fatal_o     (fatal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ckpt_re) ckpt_rdata <= 32'h100 + 32'(ckpt_raddr);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [50:0] outs();
    return {ckpt_re, ckpt_raddr, rf_we, rf_addr, pc_we, pc, halt, core_reset, recover, fatal};
  endfunction

  // Called at a negedge; runs one full recovery and finishes one cycle after done.
  task automatic recovery(input bit detail, input bit pulse);
    int reset_first = -1;
    int reset_last = -1;
    int reset_n = 0;
    int we_n = 0;
    int pc_cyc = -1;
    logic [31:0] pc_val = '0;
    logic halt1;
    error = 1'b1;
    @(negedge clk);
    error = 1'b0;
    halt1 = halt;
    for (int c = 1; c <= 60 && pc_cyc < 0; c++) begin
      if (core_reset) begin
        if (reset_n == 0) reset_first = c;
        reset_last = c;
        reset_n++;
      end
      if (rf_we) begin
        if (detail) begin
          check("rf_addr", rf_addr, we_n);
          check("rf_wdata", rf_wdata, 32'h100 + we_n);
        end
        we_n++;
      end
      if (pc_we) begin
        pc_cyc = c;
        pc_val = pc;
      end
      if (pulse && c == 20) error = 1'b1;
      if (pulse && c == 21) error = 1'b0;
      @(negedge clk);
    end
    check("pc_we_cycle", pc_cyc, 39);
    check("we_count", we_n, 32);
    if (detail) begin
      check("halt_cycle1", halt1, 1'b1);
      check("reset_first", reset_first, 2);
      check("reset_last", reset_last, 5);
      check("reset_len", reset_n, 4);
      check("pc_value", pc_val, 32'h80);
    end
    check("wait_halt", halt, 1'b0);
    check("wait_recover", recover, 1'b1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("done_recover", recover, 1'b0);
    check("done_fatal", fatal, 1'b0);
  endtask

  initial begin
    int seen;
    int bound;
    // Reset with error asserted.
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), '0);
    check("reset_wdata", rf_wdata, '0);
    error = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {halt, recover, fatal}, 3'b000);

    // Disabled: error ignored.
    enable = 1'b0;
    error = 1'b1;
    repeat (3) @(negedge clk);
    check("gated_idle", {halt, recover, core_reset}, 3'b000);
    enable = 1'b1;
    error = 1'b0;
    @(negedge clk);

    // Escalation: three recoveries (second with masked error pulse), fourth goes fatal.
    recovery(1'b1, 1'b0);
    recovery(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("no_extra_recovery", recover, 1'b0);
    recovery(1'b0, 1'b0);
    error = 1'b1;
    @(negedge clk);
    error = 1'b0;
    check("fatal_set", {fatal, halt, core_reset, recover}, 4'b1100);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      error = c[0];
      checkpoint = c[1];
      done = c[2];
      if (core_reset) seen++;
      @(negedge clk);
    end
    error = 1'b0;
    checkpoint = 1'b0;
    done = 1'b0;
    check("fatal_no_reset_pulse", seen, 0);
    check("fatal_sticky", {fatal, halt}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("fatal_cleared", outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Checkpoint clears the retry count.
    recovery(1'b0, 1'b0);
    recovery(1'b0, 1'b0);
    recovery(1'b0, 1'b0);
    checkpoint = 1'b1;
    @(negedge clk);
    checkpoint = 1'b0;
    recovery(1'b0, 1'b0);
    check("ckpt_no_fatal", fatal, 1'b0);

    // Reset in the middle of RESTORE.
    error = 1'b1;
    @(negedge clk);
    error = 1'b0;
    bound = 0;
    while (!(ckpt_re && ckpt_raddr == 6'd10) && bound < 40) begin
      @(negedge clk);
      bound++;
    end
    check("reach_idx10", ckpt_raddr, 6'd10);
    rst_n = 1'b0;
    #1;
    check("mid_restore_clear", outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (rf_we || recover) seen++;
      @(negedge clk);
    end
    check("no_write_after_reset", seen, 0);
    error = 1'b1;
    @(negedge clk);
    error = 1'b0;
    check("restart_halt", {halt, core_reset, recover}, 3'b101);
    @(negedge clk);
    check("restart_reset", core_reset, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
